// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: N:1 AXI-Stream arbiter with packet-granular round-robin.
// A grant is held from the first beat to the tlast beat. One registered output
// stage tags each beat with its source port on m_axis_tid.
module axis_packet_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned ID_WIDTH    = $clog2(NUM_PORTS)
) (
  input  logic                              aclk,
  input  logic                              areset_n,
  input  logic [NUM_PORTS-1:0]              port_enable,
  input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
  output logic [NUM_PORTS-1:0]              s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]              s_axis_tlast,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0]  s_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic [ID_WIDTH-1:0]               m_axis_tid,
  output logic                              busy
);

  localparam int unsigned KeepWidth = DATA_WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;

  logic                   m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [KeepWidth-1:0]   m_keep_q, m_keep_d;
  logic                   m_last_q, m_last_d;
  logic [TUSER_WIDTH-1:0] m_user_q, m_user_d;
  logic [ID_WIDTH-1:0]    m_id_q, m_id_d;

  logic [NUM_PORTS-1:0] req;
  logic [ID_WIDTH-1:0]  pick;
  logic                 pick_found;
  logic [31:0]          gidx;
  logic                 out_ready;
  logic                 accept;

  assign req  = s_axis_tvalid & port_enable;
  assign gidx = 32'(grant_q);

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!pick_found && req[(32'(rr_ptr_q) + i) % NUM_PORTS]) begin
        pick       = ID_WIDTH'((32'(rr_ptr_q) + i) % NUM_PORTS);
        pick_found = 1'b1;
      end
    end
  end

  // State, pointer and grant registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // Next state: lock onto the pick, release after the tlast beat is accepted.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (accept && s_axis_tlast[grant_q]) begin
          state_d  = StIdle;
          rr_ptr_d = (gidx == NUM_PORTS - 1) ? '0 : grant_q + ID_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: only the granted port sees ready, gated by output-stage space.
  always_comb begin
    s_axis_tready = '0;
    out_ready     = !m_valid_q || m_axis_tready;
    busy          = (state_q == StLocked);
    if (state_q == StLocked) begin
      s_axis_tready[grant_q] = out_ready;
    end
  end

  assign accept = (state_q == StLocked) && s_axis_tvalid[grant_q] && out_ready;

  // Output stage next value: load on acceptance, otherwise drain on ready.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    m_id_d    = m_id_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = s_axis_tdata[gidx*DATA_WIDTH +: DATA_WIDTH];
      m_keep_d  = s_axis_tkeep[gidx*KeepWidth +: KeepWidth];
      m_last_d  = s_axis_tlast[grant_q];
      m_user_d  = s_axis_tuser[gidx*TUSER_WIDTH +: TUSER_WIDTH];
      m_id_d    = grant_q;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // Output stage registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
      m_id_q    <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      m_id_q    <= m_id_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tid    = m_id_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: per-port packet queues drive the slaves, the
// output is collected and compared with a packet-level round-robin model.
module tb_axis_packet_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        first;
    logic [1:0]  id;
  } beat_t;

  logic              aclk = 1'b0;
  logic              areset_n;
  logic [NP-1:0]     port_enable;
  logic [NP-1:0]     s_axis_tvalid;
  logic [NP-1:0]     s_axis_tready;
  logic [NP*DW-1:0]  s_axis_tdata;
  logic [NP*KW-1:0]  s_axis_tkeep;
  logic [NP-1:0]     s_axis_tlast;
  logic [NP-1:0]     s_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic [0:0]        m_axis_tuser;
  logic [1:0]        m_axis_tid;
  logic              busy;

  axis_packet_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .TUSER_WIDTH(1),
    .ID_WIDTH   (2)
  ) dut (
    .aclk         (aclk),
    .areset_n     (areset_n),
    .port_enable  (port_enable),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tid   (m_axis_tid),
    .busy         (busy)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mdl_ptr = 0;
  int gap_pct = 0;
  int rdy_pct = 100;
  int acc_cnt [NP];
  bit prev_stall = 1'b0;
  bit out_first = 1'b1;
  logic [76:0] prev_m;

  beat_t src_q [NP][$];
  beat_t ref_q [NP][$];
  beat_t exp_q [$];
  beat_t out_q [$];
  int    out_cyc [$];
  bit    rdy_pat [$];

  task automatic add_packet(input int p, input int len, input logic [63:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = rnd ? {$urandom, $urandom} : base + 64'(i);
      b.keep  = rnd ? 8'($urandom) : 8'hFF;
      b.last  = (i == len - 1);
      b.user  = rnd ? 1'($urandom) : 1'b0;
      b.first = (i == 0);
      b.id    = 2'(p);
      src_q[p].push_back(b);
      ref_q[p].push_back(b);
    end
  endtask

  // Reference: move one whole packet of port p into the expected stream.
  task automatic model_pkt(input int p);
    beat_t b;
    b = '0;
    while (ref_q[p].size() > 0 && !b.last) begin
      b = ref_q[p].pop_front();
      exp_q.push_back(b);
    end
  endtask

  // Reference: packets served round-robin among enabled ports with work left.
  task automatic model_rr(input logic [NP-1:0] en);
    int p;
    while (1) begin
      p = -1;
      for (int k = 0; k < NP; k++) begin
        if (p < 0 && en[(mdl_ptr + k) % NP] && ref_q[(mdl_ptr + k) % NP].size() > 0)
          p = (mdl_ptr + k) % NP;
      end
      if (p < 0) break;
      model_pkt(p);
      mdl_ptr = (p + 1) % NP;
    end
  endtask

  task automatic drive(input logic [NP-1:0] hs);
    for (int p = 0; p < NP; p++) begin
      logic  v;
      beat_t h;
      h = '0;
      if (src_q[p].size() > 0) h = src_q[p][0];
      if (src_q[p].size() == 0) v = 1'b0;
      else if (s_axis_tvalid[p] && !hs[p]) v = 1'b1;
      else if (!h.first && ($urandom_range(99) < gap_pct)) v = 1'b0;
      else v = 1'b1;
      s_axis_tvalid[p]          = v;
      s_axis_tdata[p*DW +: DW]  = h.data;
      s_axis_tkeep[p*KW +: KW]  = h.keep;
      s_axis_tlast[p]           = h.last;
      s_axis_tuser[p]           = h.user;
    end
    if (rdy_pat.size() > 0) m_axis_tready = rdy_pat.pop_front();
    else m_axis_tready = ($urandom_range(99) < rdy_pct);
  endtask

  // One clock: sample mid-cycle, advance, then retire handshaked beats.
  task automatic step();
    logic [NP-1:0] hs;
    logic [76:0]   cur;
    beat_t         ob;
    beat_t         dummy;
    @(negedge aclk);
    hs  = s_axis_tvalid & s_axis_tready;
    cur = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tid};
    if (prev_stall) begin
      vectors++;
      if (cur !== prev_m) begin
        miscompares++;
        $display("FAIL hold_stable cyc=%0d got=%h want=%h", cyc, cur, prev_m);
      end
    end
    vectors++;
    if (!$onehot0(s_axis_tready) || (m_axis_tvalid && !m_axis_tready && s_axis_tready != '0)) begin
      miscompares++;
      $display("FAIL ready_gate cyc=%0d got=%b want=0 or onehot (mvalid=%b mready=%b)",
               cyc, s_axis_tready, m_axis_tvalid, m_axis_tready);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      ob.data  = m_axis_tdata;
      ob.keep  = m_axis_tkeep;
      ob.last  = m_axis_tlast;
      ob.user  = m_axis_tuser[0];
      ob.first = out_first;
      ob.id    = m_axis_tid;
      out_first = m_axis_tlast;
      out_q.push_back(ob);
      out_cyc.push_back(cyc);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_m     = cur;
    @(posedge aclk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (hs[p] && src_q[p].size() > 0) begin
        dummy = src_q[p].pop_front();
        acc_cnt[p]++;
      end
    end
    drive(hs);
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (out_q.size() >= n);
    repeat (8) step();
  endtask

  task automatic apply_reset();
    areset_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      ref_q[p].delete();
      acc_cnt[p] = 0;
    end
    exp_q.delete();
    out_q.delete();
    out_cyc.delete();
    rdy_pat.delete();
    port_enable = '1;
    gap_pct     = 0;
    rdy_pct     = 100;
    prev_stall  = 1'b0;
    out_first   = 1'b1;
    drive('0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset_n = 1'b1;
    @(posedge aclk);
    #1;
    mdl_ptr = 0;
  endtask

  task automatic test_reset();
    areset_n      = 1'b0;
    port_enable   = '1;
    s_axis_tvalid = '1;
    s_axis_tlast  = '1;
    s_axis_tdata  = {8{32'hDEADBEEF}};
    s_axis_tkeep  = '1;
    s_axis_tuser  = '1;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    vectors++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tid,
         s_axis_tready, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got valid=%b data=%h tid=%0d ready=%b busy=%b want all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tid, s_axis_tready, busy);
    end
    apply_reset();
    repeat (3) step();
    vectors++;
    if ({busy, m_axis_tvalid, s_axis_tready} !== '0) begin
      miscompares++;
      $display("FAIL idle_no_req got busy=%b valid=%b ready=%b want 0", busy, m_axis_tvalid,
               s_axis_tready);
    end
  endtask

  task automatic test_single_port();
    int c0;
    bit ok;
    apply_reset();
    add_packet(2, 3, 64'hA0, 1'b0);
    model_rr(port_enable);
    drive('0);
    c0 = cyc;
    run_until(3, 50, ok);
    vectors++;
    if (!ok || out_q.size() != 3) begin
      miscompares++;
      $display("FAIL single_count got=%0d want=3", out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i] || out_cyc[i] != c0 + 2 + i) begin
        miscompares++;
        $display("FAIL single_beat%0d got=%h@%0d want=%h@%0d", i, out_q[i], out_cyc[i],
                 exp_q[i], c0 + 2 + i);
      end
    end
  endtask

  task automatic test_contention();
    int ord [5] = '{0, 1, 2, 3, 0};
    bit ok;
    apply_reset();
    for (int pk = 0; pk < 2; pk++)
      for (int p = 0; p < NP; p++) add_packet(p, 2, 64'(p * 16 + pk * 4), 1'b0);
    model_rr(port_enable);
    drive('0);
    run_until(16, 200, ok);
    vectors++;
    if (!ok || out_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL contention_count got=%0d want=%0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL contention_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < 5 && 2 * k < out_q.size(); k++) begin
      vectors++;
      if (int'(out_q[2*k].id) != ord[k]) begin
        miscompares++;
        $display("FAIL contention_order%0d got=%0d want=%0d", k, out_q[2*k].id, ord[k]);
      end
    end
    for (int k = 0; k + 2 < out_cyc.size(); k += 2) begin
      vectors++;
      if (out_cyc[k+1] - out_cyc[k] != 1 || out_cyc[k+2] - out_cyc[k+1] != 2) begin
        miscompares++;
        $display("FAIL contention_gap%0d got=%0d,%0d want=1,2", k / 2,
                 out_cyc[k+1] - out_cyc[k], out_cyc[k+2] - out_cyc[k+1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int c0;
    int want [4];
    bit ok;
    apply_reset();
    add_packet(0, 4, 64'h55, 1'b0);
    model_rr(port_enable);
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    drive('0);
    c0 = cyc;
    want = '{c0 + 2, c0 + 5, c0 + 6, c0 + 7};
    run_until(4, 50, ok);
    vectors++;
    if (!ok || out_q.size() != 4) begin
      miscompares++;
      $display("FAIL bp_count got=%0d want=4", out_q.size());
    end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i] || out_cyc[i] != want[i]) begin
        miscompares++;
        $display("FAIL bp_beat%0d got=%h@%0d want=%h@%0d", i, out_q[i], out_cyc[i], exp_q[i],
                 want[i]);
      end
    end
  endtask

  task automatic test_enable_mask();
    int ord [5] = '{1, 3, 1, 3, 3};
    int k;
    bit ok;
    apply_reset();
    port_enable = 4'b1010;
    for (int pk = 0; pk < 3; pk++)
      for (int p = 0; p < NP; p++) add_packet(p, 3, 64'(p * 256 + pk * 16), 1'b0);
    for (int i = 0; i < 5; i++) model_pkt(ord[i]);
    drive('0);
    k = 0;
    while (acc_cnt[1] < 4 && k < 100) begin
      step();
      k++;
    end
    port_enable = 4'b1000;
    run_until(15, 200, ok);
    vectors++;
    if (!ok || out_q.size() != 15 || acc_cnt[1] != 6 || acc_cnt[0] != 0 || acc_cnt[2] != 0) begin
      miscompares++;
      $display("FAIL mask_count got=%0d acc=%0d/%0d/%0d want=15 acc=0/6/0", out_q.size(),
               acc_cnt[0], acc_cnt[1], acc_cnt[2]);
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL mask_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset();
    add_packet(2, 2, 64'h20, 1'b0);
    model_rr(port_enable);
    drive('0);
    run_until(2, 50, ok);
    add_packet(0, 2, 64'h00, 1'b0);
    add_packet(3, 2, 64'h30, 1'b0);
    model_rr(port_enable);
    drive('0);
    run_until(6, 50, ok);
    vectors++;
    if (!ok || out_q.size() != 6 || out_q[2].id != 2'd3 || out_q[4].id != 2'd0) begin
      miscompares++;
      $display("FAIL wrap_order got n=%0d ids=%0d,%0d want n=6 ids=3,0", out_q.size(),
               out_q[2].id, out_q[4].id);
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL wrap_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int k;
    bit ok;
    apply_reset();
    add_packet(1, 1, 64'h10, 1'b0);
    add_packet(2, 4, 64'h20, 1'b0);
    drive('0);
    k = 0;
    while (acc_cnt[2] < 2 && k < 50) begin
      step();
      k++;
    end
    vectors++;
    if (acc_cnt[2] != 2 || m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre got acc=%0d valid=%b busy=%b want 2,1,1", acc_cnt[2],
               m_axis_tvalid, busy);
    end
    #2;
    areset_n = 1'b0;
    #1;
    vectors++;
    if ({m_axis_tvalid, busy, s_axis_tready} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_async got valid=%b busy=%b ready=%b want 0", m_axis_tvalid, busy,
               s_axis_tready);
    end
    apply_reset();
    for (int p = 0; p < NP; p++) add_packet(p, 2, 64'(p * 8), 1'b0);
    model_rr(port_enable);
    drive('0);
    run_until(8, 100, ok);
    vectors++;
    if (!ok || out_q[0].id != 2'd0) begin
      miscompares++;
      $display("FAIL rst_mid_restart got n=%0d first_tid=%0d want n=8 first_tid=0",
               out_q.size(), out_q[0].id);
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rst_mid_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      port_enable = 4'($urandom_range(1, 15));
      rdy_pct     = $urandom_range(30, 100);
      gap_pct     = $urandom_range(0, 40);
      for (int p = 0; p < NP; p++)
        for (int pk = $urandom_range(0, 3); pk > 0; pk--)
          add_packet(p, $urandom_range(1, 5), 64'h0, 1'b1);
      model_rr(port_enable);
      drive('0);
      run_until(exp_q.size(), 3000, ok);
      vectors++;
      if (!ok || out_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand%0d_count got=%0d want=%0d en=%b", it, out_q.size(), exp_q.size(),
                 port_enable);
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
        vectors++;
        if (out_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand%0d_beat%0d got=%h want=%h", it, i, out_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_contention();
    test_backpressure();
    test_enable_mask();
    test_wrap();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
